// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between two writeback
// sources, with a busy scoreboard that the issue stage queries for pending destinations.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [RW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_wdata,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [RW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_wdata,
  output logic            rf_we,
  output logic [RW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            iss_valid,
  input  logic [RW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  // Handshake: a transfer happens in any cycle where valid & ready; a source holding
  // valid keeps rd/wdata stable until ready, and may drop valid without transferring.
  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

  ptr_t            ptr_q, ptr_d;
  logic            grant_a, grant_b;
  logic            wr_en;
  logic [RW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] busy_q, busy_d;

  // Pointer only advances when both sources compete.
  always_comb begin
    ptr_d   = ptr_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if (ptr_q == PTR_A) begin
        grant_a = 1'b1;
        ptr_d   = PTR_B;
      end else begin
        grant_b = 1'b1;
        ptr_d   = PTR_A;
      end
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= PTR_A;
    else       ptr_q <= ptr_d;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Writes to x0 still consume the slot but never reach the register file.
  always_comb begin
    wr_rd   = a_rd;
    wr_data = a_wdata;
    if (grant_b) begin
      wr_rd   = b_rd;
      wr_data = b_wdata;
    end
    wr_en = (grant_a || grant_b) && (wr_rd != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rd    <= wr_rd;
        rf_wdata <= wr_data;
      end
    end
  end

  assign iss_ready = !busy_q[iss_rd];
  assign rs1_busy  = busy_q[rs1];
  assign rs2_busy  = busy_q[rs2];

  // Clear on the edge the register file captures; a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) busy_d[rf_rd] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue/array reference model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, iss_ready;
  logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2, rf_rd;
  logic [31:0] a_wdata, b_wdata, rf_wdata;
  logic        rf_we, rs1_busy, rs2_busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_ptr_b;
  bit          m_busy [32];
  logic [36:0] exp_q [$];
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_wdata;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wdata(b_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_wdata = 0;
    b_valid = 0; b_rd = 0; b_wdata = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_ptr_b = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    exp_q.delete();
    m_last_rd = 0;
    m_last_wdata = 0;
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got=%0h exp=0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
    // contention in cycle 0 moves the pointer to B before reset
    a_valid = 1; a_rd = 5; a_wdata = 32'hAA;
    b_valid = 1; b_rd = 6; b_wdata = 32'hBB;
    iss_valid = 1; iss_rd = 12;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_pre_a_ready got=%0h exp=1", a_ready); end
    step();
    idle_inputs();
    rs1 = 12;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL reset_inflight_we got=%0h exp=1", rf_we); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy12 got=%0h exp=1", rs1_busy); end
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_async_we got=%0h exp=0", rf_we); end
    checks++; if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_async_rf got=%0h/%0h exp=0/0", rf_rd, rf_wdata); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy got=%0h exp=0", rs1_busy); end
    step();
    reset = 1'b0;
    a_valid = 1; a_rd = 1; a_wdata = 1;
    b_valid = 1; b_rd = 2; b_wdata = 2;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL reset_ptr_a got=%b exp=10", {a_ready, b_ready}); end
    step();
    a_valid = 0;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL reset_b_alone got=%b exp=01", {a_ready, b_ready}); end
    step();
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1; a_rd = 3; a_wdata = 32'h1234;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {a_ready, b_ready}); end
    step();
    a_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h1234) begin errors++;
      $display("FAIL single_write got=%0h/%0h/%0h exp=1/3/1234", rf_we, rf_rd, rf_wdata); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_ready_novalid got=%0h exp=0", a_ready); end
    step();
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd3 || rf_wdata !== 32'h1234) begin errors++;
      $display("FAIL single_hold got=%0h/%0h/%0h exp=0/3/1234", rf_we, rf_rd, rf_wdata); end
  endtask

  task automatic test_contention();
    logic [4:0]  prev_rd;
    logic [31:0] prev_wd;
    logic        exp_a;
    do_reset();
    a_valid = 1; a_rd = 1; a_wdata = 32'hA0;
    b_valid = 1; b_rd = 2; b_wdata = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_a = (k % 2 == 0);
      checks++; if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin errors++;
        $display("FAIL contention_grant%0d got=%b exp=%b", k, {a_ready, b_ready}, {exp_a, !exp_a}); end
      if (k > 0) begin
        checks++; if (rf_we !== 1'b1 || rf_rd !== prev_rd || rf_wdata !== prev_wd) begin errors++;
          $display("FAIL contention_write%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, rf_we, rf_rd, rf_wdata, prev_rd, prev_wd); end
      end
      prev_rd = exp_a ? a_rd : b_rd;
      prev_wd = exp_a ? a_wdata : b_wdata;
      step();
      if (exp_a) a_wdata = a_wdata + 1;
      else       b_wdata = b_wdata + 1;
    end
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== prev_rd || rf_wdata !== prev_wd) begin errors++;
      $display("FAIL contention_last got=%0h/%0h/%0h exp=1/%0h/%0h", rf_we, rf_rd, rf_wdata, prev_rd, prev_wd); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_valid = 1; iss_rd = 7; rs1 = 7;
    #1;
    checks++; if (iss_ready !== 1'b1 || rs1_busy !== 1'b0) begin errors++;
      $display("FAIL sb_c0 got=%0h/%0h exp=1/0", iss_ready, rs1_busy); end
    step();
    iss_valid = 0;
    for (int c = 1; c < 4; c++) begin
      checks++; if (rs1_busy !== 1'b1 || iss_ready !== 1'b0) begin errors++;
        $display("FAIL sb_busy_c%0d got=%0h/%0h exp=1/0", c, rs1_busy, iss_ready); end
      step();
    end
    b_valid = 1; b_rd = 7; b_wdata = 32'h77;
    #1;
    checks++; if (b_ready !== 1'b1 || rs1_busy !== 1'b1) begin errors++;
      $display("FAIL sb_c4 got=%0h/%0h exp=1/1", b_ready, rs1_busy); end
    step();
    b_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rs1_busy !== 1'b1) begin errors++;
      $display("FAIL sb_c5 got=%0h/%0h/%0h exp=1/7/1", rf_we, rf_rd, rs1_busy); end
    step();
    checks++; if (rs1_busy !== 1'b0 || iss_ready !== 1'b1) begin errors++;
      $display("FAIL sb_c6 got=%0h/%0h exp=0/1", rs1_busy, iss_ready); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    b_valid = 1; b_rd = 9; b_wdata = 32'h99;
    step();
    b_valid = 0;
    iss_valid = 1; iss_rd = 9; rs2 = 9;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || iss_ready !== 1'b1) begin errors++;
      $display("FAIL setclr_pre got=%0h/%0h/%0h exp=1/9/1", rf_we, rf_rd, iss_ready); end
    step();
    iss_valid = 0;
    #1;
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL setclr_post got=%0h exp=1", rs2_busy); end
  endtask

  task automatic test_x0();
    do_reset();
    a_valid = 1; a_rd = 0; a_wdata = 32'h55;
    b_valid = 1; b_rd = 4; b_wdata = 32'h44;
    iss_valid = 1; iss_rd = 0; rs2 = 0;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10 || iss_ready !== 1'b1) begin errors++;
      $display("FAIL x0_accept got=%b/%0h exp=10/1", {a_ready, b_ready}, iss_ready); end
    step();
    a_valid = 0; a_rd = 0;
    a_valid = 1; a_wdata = 32'h56;
    #1;
    checks++; if (rf_we !== 1'b0 || rs2_busy !== 1'b0) begin errors++;
      $display("FAIL x0_no_write got=%0h/%0h exp=0/0", rf_we, rs2_busy); end
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++;
      $display("FAIL x0_counts_arb got=%b exp=01", {a_ready, b_ready}); end
    step();
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rs2_busy !== 1'b0) begin errors++;
      $display("FAIL x0_b_write got=%0h/%0h/%0h exp=1/4/0", rf_we, rf_rd, rs2_busy); end
  endtask

  task automatic test_random();
    bit          a_hold, b_hold, exp_ga, exp_gb, exp_ir, exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    do_reset();
    a_hold = 0; b_hold = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 9) < 6); a_rd = rnd_rd(); a_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) a_valid = 0;
      if (!b_hold) begin
        b_valid = ($urandom_range(0, 9) < 6); b_rd = rnd_rd(); b_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) b_valid = 0;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = rnd_rd(); rs1 = rnd_rd(); rs2 = rnd_rd();
      #1;
      exp_ga = a_valid && (!b_valid || !m_ptr_b);
      exp_gb = b_valid && (!a_valid || m_ptr_b);
      exp_ir = (iss_rd == 0) || !m_busy[iss_rd];
      if (exp_q.size() > 0) begin
        exp_we = 1; {exp_rd, exp_wd} = exp_q[0];
      end else begin
        exp_we = 0; exp_rd = m_last_rd; exp_wd = m_last_wdata;
      end
      checks++; if ({a_ready, b_ready} !== {exp_ga, exp_gb}) begin errors++;
        $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, {a_ready, b_ready}, {exp_ga, exp_gb}); end
      checks++; if (iss_ready !== exp_ir) begin errors++;
        $display("FAIL rnd_iss_ready cyc=%0d rd=%0d got=%0h exp=%0h", cyc, iss_rd, iss_ready, exp_ir); end
      checks++; if (rs1_busy !== m_busy[rs1] || rs2_busy !== m_busy[rs2]) begin errors++;
        $display("FAIL rnd_rs_busy cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, rs1_busy, rs2_busy, m_busy[rs1], m_busy[rs2]); end
      checks++; if (rf_we !== exp_we || rf_rd !== exp_rd || rf_wdata !== exp_wd) begin errors++;
        $display("FAIL rnd_rf cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, rf_we, rf_rd, rf_wdata, exp_we, exp_rd, exp_wd); end
      if (exp_we) begin
        void'(exp_q.pop_front());
        m_busy[exp_rd] = 0;
        m_last_rd = exp_rd;
        m_last_wdata = exp_wd;
      end
      if (iss_valid && exp_ir && iss_rd != 0) m_busy[iss_rd] = 1;
      if (exp_ga && a_rd != 0) exp_q.push_back({a_rd, a_wdata});
      if (exp_gb && b_rd != 0) exp_q.push_back({b_rd, b_wdata});
      if (a_valid && b_valid) m_ptr_b = !m_ptr_b;
      a_hold = a_valid && !exp_ga;
      b_hold = b_valid && !exp_gb;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_x0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
